// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM receive path: FSM encoding and default frame geometry.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int TDM_N     = 8;
    localparam int TDM_SEL_W = 3;

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-N slot index counter with clear, load-to-1 and enable (priority in that order).
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int N     = TDM_N,
    parameter int SEL_W = TDM_SEL_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load1_i,
    input  logic             en_i,
    output logic [SEL_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [SEL_W-1:0] cnt_q;

    // N is a power of two, so the natural SEL_W-bit wrap is the modulo-N wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load1_i) begin
            cnt_q <= SEL_W'(1);
        end else if (en_i) begin
            cnt_q <= cnt_q + SEL_W'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == SEL_W'(N - 1));

endmodule

// File: rtl/tdm_demux8.sv
// TDM receive demultiplexer: locks to the frame marker, assembles a frame in a shadow
// register and publishes it to w on completion, flagging sync violations.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int N     = TDM_N,
    parameter int SEL_W = TDM_SEL_W
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             f,
    input  logic             valid,
    input  logic             sync,
    output logic [N-1:0]     w,
    output logic [SEL_W-1:0] S,
    output logic             locked,
    output logic             frame_valid,
    output logic             sync_err
);

    state_e           state_q;
    logic [N-1:0]     shadow_q;
    logic [N-1:0]     w_q;
    logic             fv_q;
    logic             err_q;

    logic [SEL_W-1:0] slot;
    logic             slot_tc;
    logic             cnt_clr;
    logic             cnt_load1;
    logic             cnt_en;
    logic [N-1:0]     shadow_ins;

    tdm_slot_counter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk_i   (Clock),
        .rst_ni  (Resetn),
        .clr_i   (cnt_clr),
        .load1_i (cnt_load1),
        .en_i    (cnt_en),
        .cnt_o   (slot),
        .tc_o    (slot_tc)
    );

    // Shadow with the current bit already inserted, so the last slot can go straight to w.
    always_comb begin
        shadow_ins       = shadow_q;
        shadow_ins[slot] = f;
        cnt_clr          = 1'b0;
        cnt_load1        = 1'b0;
        cnt_en           = 1'b0;
        if (valid) begin
            if (state_q == HUNT) begin
                cnt_load1 = sync;
            end else if (sync) begin
                cnt_load1 = 1'b1;
            end else if (slot == '0) begin
                cnt_clr = 1'b1;
            end else begin
                cnt_en = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= HUNT;
            shadow_q <= '0;
            w_q      <= '0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fv_q  <= 1'b0;
            err_q <= 1'b0;
            if (valid) begin
                if (state_q == HUNT) begin
                    if (sync) begin
                        shadow_q[0] <= f;
                        state_q     <= LOCKED;
                    end
                end else if (sync) begin
                    // A marker anywhere but slot 0 realigns; it also beats frame completion.
                    shadow_q[0] <= f;
                    err_q       <= (slot != '0);
                end else if (slot == '0) begin
                    err_q   <= 1'b1;
                    state_q <= HUNT;
                end else begin
                    shadow_q <= shadow_ins;
                    if (slot_tc) begin
                        w_q  <= shadow_ins;
                        fv_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign w           = w_q;
    assign S           = slot;
    assign locked      = (state_q == LOCKED);
    assign frame_valid = fv_q;
    assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed self-checking bench for tdm_demux8.
module tb_tdm_demux8;

    logic       Clock;
    logic       Resetn;
    logic       f;
    logic       valid;
    logic       sync;
    logic [7:0] w;
    logic [2:0] S;
    logic       locked;
    logic       frame_valid;
    logic       sync_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tdm_demux8 dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .f           (f),
        .valid       (valid),
        .sync        (sync),
        .w           (w),
        .S           (S),
        .locked      (locked),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one input cycle, then look at the outputs just after the edge that sampled it.
    task automatic send(input logic v, input logic s, input logic b);
        @(negedge Clock);
        valid = v;
        sync  = s;
        f     = b;
        @(posedge Clock);
        #1;
        cyc++;
        check("fv_err_exclusive", {31'd0, frame_valid & sync_err}, 32'd0);
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] b2b [3];
        int         fv_cyc [3];

        Resetn = 1'b0;
        f      = 1'b0;
        valid  = 1'b1;
        sync   = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_w", {24'd0, w}, 32'h0);
        check("rst_S", {29'd0, S}, 32'h0);
        check("rst_locked", {31'd0, locked}, 32'h0);
        check("rst_pulses", {30'd0, frame_valid, sync_err}, 32'h0);

        @(negedge Clock);
        Resetn = 1'b1;
        valid  = 1'b0;
        sync   = 1'b0;
        repeat (5) send(1'b0, 1'b0, 1'b0);
        check("idle_locked", {31'd0, locked}, 32'h0);
        check("idle_S", {29'd0, S}, 32'h0);
        check("idle_w", {24'd0, w}, 32'h0);

        // Lock and one frame: slot order 1,0,1,1,0,0,1,0
        pat = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, (i == 0), pat[i]);
            if (i == 0) begin
                check("lock_locked", {31'd0, locked}, 32'h1);
                check("lock_S1", {29'd0, S}, 32'h1);
            end
            if (i < 7) check("frame1_no_fv", {31'd0, frame_valid}, 32'h0);
        end
        check("frame1_fv", {31'd0, frame_valid}, 32'h1);
        check("frame1_w", {24'd0, w}, 32'h4D);
        check("frame1_S_wrap", {29'd0, S}, 32'h0);
        check("frame1_err", {31'd0, sync_err}, 32'h0);
        send(1'b0, 1'b0, 1'b0);
        check("frame1_fv_pulse", {31'd0, frame_valid}, 32'h0);
        check("frame1_w_hold", {24'd0, w}, 32'h4D);

        // Gapped frame, with sync asserted without valid in the gaps
        for (int i = 0; i < 8; i++) begin
            send(1'b1, (i == 0), pat[i]);
            if (i == 7) begin
                check("gap_fv", {31'd0, frame_valid}, 32'h1);
                check("gap_w", {24'd0, w}, 32'h4D);
            end
            for (int g = 0; g < 3; g++) begin
                send(1'b0, 1'b1, ~pat[i]);
                check("gap_S_hold", {29'd0, S}, (i + 1) % 8);
                check("gap_no_fv", {31'd0, frame_valid}, 32'h0);
            end
        end
        check("gap_locked", {31'd0, locked}, 32'h1);

        // Early sync: 5 bits, then resync with f=1, then 7 zeros
        for (int i = 0; i < 5; i++) send(1'b1, (i == 0), 1'b1);
        check("early_S5", {29'd0, S}, 32'h5);
        send(1'b1, 1'b1, 1'b1);
        check("early_err", {31'd0, sync_err}, 32'h1);
        check("early_S1", {29'd0, S}, 32'h1);
        check("early_locked", {31'd0, locked}, 32'h1);
        check("early_w_hold", {24'd0, w}, 32'h4D);
        for (int i = 1; i < 8; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (i == 1) check("early_err_pulse", {31'd0, sync_err}, 32'h0);
            if (i < 7) check("early_no_fv", {31'd0, frame_valid}, 32'h0);
        end
        check("early_fv", {31'd0, frame_valid}, 32'h1);
        check("early_w", {24'd0, w}, 32'h01);

        // Sync at the last slot: realign instead of completing
        for (int i = 0; i < 7; i++) send(1'b1, (i == 0), 1'b1);
        check("tcsync_S7", {29'd0, S}, 32'h7);
        send(1'b1, 1'b1, 1'b0);
        check("tcsync_no_fv", {31'd0, frame_valid}, 32'h0);
        check("tcsync_err", {31'd0, sync_err}, 32'h1);
        check("tcsync_S1", {29'd0, S}, 32'h1);
        check("tcsync_w_hold", {24'd0, w}, 32'h01);
        for (int i = 1; i < 8; i++) send(1'b1, 1'b0, 1'b1);
        check("tcsync_fv", {31'd0, frame_valid}, 32'h1);
        check("tcsync_w", {24'd0, w}, 32'hFE);

        // Lost sync at slot 0
        send(1'b1, 1'b0, 1'b1);
        check("lost_err", {31'd0, sync_err}, 32'h1);
        check("lost_locked", {31'd0, locked}, 32'h0);
        check("lost_S", {29'd0, S}, 32'h0);
        check("lost_w_hold", {24'd0, w}, 32'hFE);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0, 1'b1);
            check("hunt_ignore_locked", {31'd0, locked}, 32'h0);
            check("hunt_ignore_S", {29'd0, S}, 32'h0);
            check("hunt_no_err", {31'd0, sync_err}, 32'h0);
        end
        send(1'b0, 1'b1, 1'b1);
        check("hunt_sync_novalid", {31'd0, locked}, 32'h0);
        send(1'b1, 1'b1, 1'b1);
        check("relock_locked", {31'd0, locked}, 32'h1);
        check("relock_S", {29'd0, S}, 32'h1);
        check("relock_no_err", {31'd0, sync_err}, 32'h0);
        for (int i = 1; i < 8; i++) send(1'b1, 1'b0, 1'b0);
        check("relock_fv", {31'd0, frame_valid}, 32'h1);
        check("relock_w", {24'd0, w}, 32'h01);

        // Three back-to-back frames
        b2b[0] = 8'hA5;
        b2b[1] = 8'h3C;
        b2b[2] = 8'h96;
        for (int fr = 0; fr < 3; fr++) begin
            pat = b2b[fr];
            for (int i = 0; i < 8; i++) begin
                send(1'b1, (i == 0), pat[i]);
                if (i < 7) check("b2b_no_fv", {31'd0, frame_valid}, 32'h0);
            end
            check("b2b_fv", {31'd0, frame_valid}, 32'h1);
            check("b2b_w", {24'd0, w}, {24'd0, b2b[fr]});
            fv_cyc[fr] = cyc;
        end
        check("b2b_spacing01", fv_cyc[1] - fv_cyc[0], 32'd8);
        check("b2b_spacing12", fv_cyc[2] - fv_cyc[1], 32'd8);

        // Fourth frame interrupted by reset at slot 4
        pat = 8'hFF;
        for (int i = 0; i < 4; i++) send(1'b1, (i == 0), pat[i]);
        check("mid_S4", {29'd0, S}, 32'h4);
        @(negedge Clock);
        valid  = 1'b1;
        sync   = 1'b0;
        f      = 1'b1;
        Resetn = 1'b0;
        #1;
        check("midrst_w", {24'd0, w}, 32'h0);
        check("midrst_S", {29'd0, S}, 32'h0);
        check("midrst_locked", {31'd0, locked}, 32'h0);
        check("midrst_pulses", {30'd0, frame_valid, sync_err}, 32'h0);
        @(negedge Clock);
        Resetn = 1'b1;
        send(1'b1, 1'b0, 1'b1);
        check("postrst_hunt", {31'd0, locked}, 32'h0);
        check("postrst_S", {29'd0, S}, 32'h0);
        send(1'b1, 1'b1, 1'b0);
        check("postrst_relock", {31'd0, locked}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Receive-side time-division demultiplexer for the 8:1 selector path. It takes the single serial line `f` produced by an 8:1 mux driven with a counting select, and recovers the eight channels into registered parallel outputs `w[7:0]`, one full frame at a time. It locks to a frame-sync marker, tracks the current slot, and flags sync errors. It sits at the far end of the serial link, ahead of channel consumers that need stable per-frame samples.

## Interface
Parameters:
- `N` — default 8 — number of channels/slots per frame; power of two, ≥2.
- `SEL_W` — default 3 — slot index width, equal to log2(N).

Ports:
- `Clock` — in — 1 — single clock; all state updates on the rising edge.
- `Resetn` — in — 1 — reset is asynchronous and active-low.
- `f` — in — 1 — serial TDM data bit.
- `valid` — in — 1 — `f` carries a slot bit this cycle; gaps of any length are allowed.
- `sync` — in — 1 — frame marker; qualified by `valid`; marks the slot-0 bit.
- `w` — out — N — registered recovered channels; `w[i]` is the slot-i bit of the last complete frame.
- `S` — out — SEL_W — slot index the next valid bit will be written to.
- `locked` — out — 1 — high in LOCKED state.
- `frame_valid` — out — 1 — one-cycle pulse when `w` updates.
- `sync_err` — out — 1 — one-cycle pulse on a detected sync violation.

## Operation
- Internal N-bit shadow register accumulates the current frame. `w` changes only on frame completion.
- FSM has two states: HUNT and LOCKED.
- **HUNT:** bits with `valid & ~sync` are discarded.
  - On `valid & sync`: write `f` to shadow[0], set `S`=1, go to LOCKED.
- **LOCKED**, valid bit with `S`≠0 and `sync`=0:
  - Write shadow[`S`]=`f`, then `S`=`S`+1, wrapping mod N.
- **LOCKED**, valid bit with `S`=N−1:
  - Copy shadow with this final bit inserted into `w`.
  - Pulse `frame_valid`.
  - Set `S` to 0.
- **LOCKED**, valid bit with `S`=0:
  - `sync`=1: normal frame start. Write slot 0 and set `S`=1.
  - `sync`=0: lost sync. Pulse `sync_err`, discard the bit, go to HUNT, set `S`=0.
- **LOCKED**, valid bit with `sync`=1 and `S`≠0 (early sync):
  - Pulse `sync_err`.
  - Discard the partial frame; `w` is unchanged.
  - Realign: this bit becomes slot 0, `S`=1, stay LOCKED.
- Early sync takes precedence over frame completion. With `sync`=1 at `S`=N−1, there is no `frame_valid`; the bit is treated as slot 0.
- `valid`=0: no state, `S`, or shadow change. Pulses deassert.
- `sync` without `valid` is ignored everywhere.
- `S` counts modulo N; the wrap from N−1 to 0 happens only on a valid bit.

## Timing
- Reset values (asynchronous, while `Resetn`=0):
  - `w`=0, `S`=0, `locked`=0, `frame_valid`=0, `sync_err`=0.
  - Shadow register = 0, state = HUNT.
- Latency: the slot N−1 bit is sampled at edge k. `w` and `frame_valid` are valid after edge k (visible in cycle k+1).
- `frame_valid` and `sync_err` are single-cycle pulses, registered. They are never high together.
- `locked` rises the cycle after the first valid sync bit. It falls the cycle after a missed-sync bit.
- Minimum frame time is N consecutive valid cycles. Back-to-back frames sustain one `frame_valid` every N valid bits.
- Reset mid-frame: the partial frame is lost, `w` clears to 0, and relock requires a new `valid & sync`.

## Structure
- Shared package `tdm_pkg`: state encoding (HUNT=0, LOCKED=1), default `N`=8, `SEL_W`=3.
- One sub-module: `tdm_slot_counter`. It is a SEL_W-bit modulo-N counter with synchronous load-to-1, clear, and enable inputs, plus a terminal-count output (`S`==N−1).
- Top level contains the FSM, shadow register, output register, and pulse logic.

## Test plan
- **Reset/idle:** assert `Resetn`=0 mid-stream → all outputs 0; release with `valid`=0 for 5 cycles → outputs stay 0, `locked`=0.
- **Lock and one frame:** 8 consecutive valid bits 1,0,1,1,0,0,1,0 (slot 0 first), `sync`=1 on the first → `frame_valid` one cycle after the 8th bit, `w`=8'b01001101, `locked`=1.
- **Gapped frame:** same bits with `valid`=0 for 3 cycles between each bit → identical `w`; `S` holds during gaps.
- **Early sync:** lock, send 5 bits, then `valid & sync` with `f`=1, then 7 more bits all 0 → `sync_err` pulse at the resync bit; the first partial frame produces no `frame_valid`; then `w`=8'b00000001.
- **Lost sync:** after a good frame, next slot-0 bit has `sync`=0 → `sync_err` pulse, `locked`=0, `w` holds its previous value; following bits without sync are ignored until `valid & sync`.
- **Back-to-back plus reset mid-frame:** 3 continuous frames → 3 `frame_valid` pulses spaced 8 cycles apart; assert `Resetn` low at slot 4 of the 4th frame → `w`=0, HUNT state.
